// File: rtl/measurement_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : measurement_stream_tx
//  Description : Packs syndrome measurement rounds into a header-prefixed byte
//                stream for the decoder controller; also sends START_DECODING.
//                Optional macro INTER_ROUND_GAP_EN inserts a one-cycle idle
//                gap between rounds of a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module measurement_stream_tx #(
    parameter int         GRID_WIDTH_X = 3,
    parameter int         GRID_WIDTH_Z = 2,
    parameter int         GRID_WIDTH_U = 3,
    parameter logic [7:0] START_BYTE   = 8'h01,
    parameter logic [7:0] HEADER_BYTE  = 8'h02
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start_valid,
    output logic                                 start_ready,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0] round_data,
    input  logic                                 round_valid,
    output logic                                 round_ready,
    output logic [7:0]                           tx_data,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic [15:0]                          frame_count
);

    localparam int c_pu_count_per_round = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int c_bytes_per_round    = (c_pu_count_per_round + 7) / 8;
    localparam int c_shadow_w           = 8 * c_bytes_per_round;
    localparam int c_byte_cnt_w         = $clog2(c_bytes_per_round + 1);
    localparam int c_round_cnt_w        = $clog2(GRID_WIDTH_U + 1);
    localparam logic [c_byte_cnt_w-1:0]  c_last_byte  = c_byte_cnt_w'(c_bytes_per_round - 1);
    localparam logic [c_round_cnt_w-1:0] c_last_round = c_round_cnt_w'(GRID_WIDTH_U - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_HEADER     = 3'd2,
        S_WAIT_ROUND = 3'd3,
        S_SEND       = 3'd4
`ifdef INTER_ROUND_GAP_EN
        , S_GAP      = 3'd5
`endif
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_shadow_w-1:0]     r_shadow;
    logic [c_shadow_w-1:0]     w_round_ext;
    logic [c_byte_cnt_w-1:0]   r_byte_cnt;
    logic [c_round_cnt_w-1:0]  r_round_cnt;
    logic                      r_start_ready;
    logic                      r_frame_done;
    logic [15:0]               r_frame_count;
    logic [7:0]                w_send_byte;
    logic [7:0]                w_tx_data;
    logic                      w_tx_valid;
    logic                      w_round_ready;
    logic                      w_start_accept;
    logic                      w_frame_end;

    always_comb begin
        w_round_ext = '0;
        w_round_ext[c_pu_count_per_round-1:0] = round_data;
    end

    // byte_cnt 0 addresses the most-significant byte of the shadow register
    always_comb begin
        w_send_byte = '0;
        for (int i = 0; i < c_bytes_per_round; i++) begin
            if (r_byte_cnt == c_byte_cnt_w'(c_bytes_per_round - 1 - i))
                w_send_byte = r_shadow[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tx_data      = '0;
        w_tx_valid     = 1'b0;
        w_round_ready  = 1'b0;
        w_start_accept = 1'b0;
        w_frame_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_start_accept = 1'b1;
                    w_state_nxt    = S_START;
                end else if (round_valid) begin
                    w_state_nxt = S_HEADER;
                end
            end
            S_START: begin
                w_tx_data  = START_BYTE;
                w_tx_valid = 1'b1;
                if (tx_ready) w_state_nxt = S_IDLE;
            end
            S_HEADER: begin
                w_tx_data  = HEADER_BYTE;
                w_tx_valid = 1'b1;
                if (tx_ready) w_state_nxt = S_WAIT_ROUND;
            end
            S_WAIT_ROUND: begin
                w_round_ready = 1'b1;
                if (round_valid) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_tx_data  = w_send_byte;
                w_tx_valid = 1'b1;
                if (tx_ready && (r_byte_cnt == c_last_byte)) begin
                    if (r_round_cnt == c_last_round) begin
                        w_frame_end = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
`ifdef INTER_ROUND_GAP_EN
                        w_state_nxt = S_GAP;
`else
                        w_state_nxt = S_WAIT_ROUND;
`endif
                    end
                end
            end
`ifdef INTER_ROUND_GAP_EN
            S_GAP: w_state_nxt = S_WAIT_ROUND;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow      <= '0;
            r_byte_cnt    <= '0;
            r_round_cnt   <= '0;
            r_start_ready <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_start_ready <= w_start_accept;
            r_frame_done  <= w_frame_end;
            if (w_frame_end)
                r_frame_count <= r_frame_count + 16'd1;
            if ((r_state == S_HEADER) && tx_ready)
                r_round_cnt <= '0;
            if ((r_state == S_WAIT_ROUND) && round_valid) begin
                r_shadow   <= w_round_ext;
                r_byte_cnt <= '0;
            end
            if ((r_state == S_SEND) && tx_ready) begin
                if (r_byte_cnt == c_last_byte) begin
                    r_byte_cnt  <= '0;
                    r_round_cnt <= r_round_cnt + 1'b1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end
        end
    end

    assign start_ready = r_start_ready;
    assign round_ready = w_round_ready;
    assign tx_data     = w_tx_data;
    assign tx_valid    = w_tx_valid;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
